system_mutex_lock_master: RTL

Hardware Avalon-MM master that acquires and releases a system hardware mutex for a non-CPU client, such as a DMA engine or accelerator, that must share the on-chip memory with software. It connects directly upstream of the mutex slave (data register at address 0, reset flag at address 1) and hides the write-then-verify acquire protocol behind a level request/grant handshake. It retries with a programmable back-off and can give up after a bounded number of attempts.

---
 rtl/system_mutex_lock_master.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/system_mutex_lock_master.sv
`default_nettype none
// ============================================================================
// Module   : system_mutex_lock_master
// Purpose  : Avalon-MM master that acquires and releases a hardware mutex
//            for a non-CPU client. It hides the write-then-verify acquire
//            protocol behind a level request/grant handshake. Failed attempts
//            are retried after a programmable back-off. An optional attempt
//            limit makes the block give up.
// Ports    : clk, reset          - clock, asynchronous active-high reset
//            acq_req, rel_req    - client level request / release request
//            granted, fail       - lock owned / gave up after MAX_ATTEMPTS
//            attempts            - attempts in current acquire (saturating)
//            last_owner          - owner field seen on last failed verify
//            m_*                 - Avalon-MM master towards the mutex slave
// Revision : 1.0 - initial release
// ============================================================================
module system_mutex_lock_master #(
  parameter logic [15:0] OWNER_ID     = 16'h0002,
  parameter logic [15:0] LOCK_VALUE   = 16'h0001,
  parameter int unsigned RETRY_DELAY  = 4,
  parameter int unsigned MAX_ATTEMPTS = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        acq_req,
  input  logic        rel_req,
  output logic        granted,
  output logic        fail,
  output logic [7:0]  attempts,
  output logic [15:0] last_owner,
  output logic        m_address,
  output logic        m_chipselect,
  output logic        m_write,
  output logic        m_read,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_ACQ_WR = 3'd1;
  localparam logic [2:0] c_ACQ_RD = 3'd2;
  localparam logic [2:0] c_WAIT   = 3'd3;
  localparam logic [2:0] c_HELD   = 3'd4;
  localparam logic [2:0] c_REL_WR = 3'd5;
  localparam logic [2:0] c_FAIL   = 3'd6;

  localparam logic [31:0] c_LOCK_WORD    = {OWNER_ID, LOCK_VALUE};
  localparam logic [31:0] c_RELEASE_WORD = {OWNER_ID, 16'h0000};
  localparam logic [7:0]  c_RETRY_DELAY  = RETRY_DELAY[7:0];
  localparam logic [7:0]  c_MAX_ATTEMPTS = MAX_ATTEMPTS[7:0];

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [7:0]  r_attempts;
  logic [15:0] r_last_owner;
  logic [7:0]  r_delay;
  logic        w_match;
  logic        w_limit;

  // The mutex slave answers in the same cycle as the read strobe, so the
  // verify decision is taken directly on m_readdata during ACQ_RD.
  assign w_match = (m_readdata == c_LOCK_WORD);
  // r_attempts already includes the attempt being verified.
  assign w_limit = (c_MAX_ATTEMPTS != 8'd0) && (r_attempts >= c_MAX_ATTEMPTS);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (acq_req) w_next = c_ACQ_WR;
      end
      c_ACQ_WR: begin
        w_next = c_ACQ_RD;
      end
      c_ACQ_RD: begin
        if (w_match) begin
          // A won lock must be given back if the client already left.
          w_next = acq_req ? c_HELD : c_REL_WR;
        end else if (w_limit) begin
          w_next = c_FAIL;
        end else begin
          w_next = acq_req ? c_WAIT : c_IDLE;
        end
      end
      c_WAIT: begin
        if (!acq_req) begin
          w_next = c_IDLE;
        end else if (r_delay <= 8'd1) begin
          w_next = c_ACQ_WR;
        end
      end
      c_HELD: begin
        if (rel_req || !acq_req) w_next = c_REL_WR;
      end
      c_REL_WR: begin
        w_next = c_IDLE;
      end
      c_FAIL: begin
        if (!acq_req) w_next = c_IDLE;
      end
      default: begin
        w_next = c_IDLE;
      end
    endcase
  end

  // Attempt counter, captured owner and back-off counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_attempts   <= 8'd0;
      r_last_owner <= 16'd0;
      r_delay      <= 8'd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (acq_req) r_attempts <= 8'd0;
        end
        c_ACQ_WR: begin
          if (r_attempts != 8'hFF) r_attempts <= r_attempts + 8'd1;
        end
        c_ACQ_RD: begin
          if (!w_match) begin
            r_last_owner <= m_readdata[31:16];
            r_delay      <= c_RETRY_DELAY;
          end
        end
        c_WAIT: begin
          r_delay <= r_delay - 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Moore output decode; address 1 (reset flag) is never selected.
  always_comb begin
    granted      = 1'b0;
    fail         = 1'b0;
    m_address    = 1'b0;
    m_chipselect = 1'b0;
    m_write      = 1'b0;
    m_read       = 1'b0;
    m_writedata  = 32'd0;
    case (r_state)
      c_ACQ_WR: begin
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_writedata  = c_LOCK_WORD;
      end
      c_ACQ_RD: begin
        m_chipselect = 1'b1;
        m_read       = 1'b1;
      end
      c_HELD: begin
        granted = 1'b1;
      end
      c_REL_WR: begin
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_writedata  = c_RELEASE_WORD;
      end
      c_FAIL: begin
        fail = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign attempts   = r_attempts;
  assign last_owner = r_last_owner;

endmodule
`default_nettype wire
